// File: rtl/recover_2n_sched.sv
// recover_2n_sched: issue sequencer for the 2N-point recovery butterfly stage.
// Walks one frame of column-pair beats, reads the pair buffer, feeds the
// fixed-latency recovery datapath, writes results back by returned index and
// flags out-of-order returns.
// Optional build macro RECOVER_2N_SCHED_STATS_EN adds stall_cycles/frame_cycles.
module recover_2n_sched #(
  parameter int IDX_W        = 11,
  parameter int RD_LAT       = 1,
  parameter int DP_LAT       = 7,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       len_log2,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef RECOVER_2N_SCHED_STATS_EN
  output logic [15:0]      stall_cycles,
  output logic [15:0]      frame_cycles,
`endif
  input  logic             sink_stall,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr_col1,
  output logic [IDX_W-1:0] rd_addr_col2,
  output logic             dp_valid,
  output logic [IDX_W-1:0] dp_index_col1,
  output logic [IDX_W-1:0] dp_index_col2,
  input  logic             dp_ready,
  input  logic [IDX_W-1:0] dp_out_index_col1,
  input  logic [IDX_W-1:0] dp_out_index_col2,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr_col1,
  output logic [IDX_W-1:0] wr_addr_col2
);

  localparam int               INF_W   = 4;
  localparam logic [INF_W-1:0] MAX_INF = INF_W'(MAX_INFLIGHT);
  localparam logic [3:0]       LEN_MAX = 4'(IDX_W);

  // Datapath latency is a property of the partner block; it is only checked here.
  if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > 15 || RD_LAT < 0 || DP_LAT < 1) begin : g_param_check
    $error("recover_2n_sched: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] beats_q;
  logic [IDX_W-1:0] issue_cnt;
  logic [IDX_W-1:0] ret_cnt;
  logic [INF_W-1:0] inflight;

  logic len_ok;
  logic start_acc;
  logic can_issue;
  logic issue_now;
  logic ret_now;

  // Issue/return qualifiers shared by the FSM, the in-flight counter and stats.
  always_comb begin
    len_ok    = (len_log2 >= 4'd2) && (len_log2 <= LEN_MAX);
    start_acc = (state == IDLE) && start;
    can_issue = !sink_stall && (inflight < MAX_INF);
    issue_now = (start_acc && len_ok && !sink_stall) || ((state == ISSUE) && can_issue);
    ret_now   = dp_ready && busy;
  end

  // Beats between read strobe and datapath return; simultaneous issue and return cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue_now && !ret_now) begin
      inflight <= inflight + INF_W'(1);
    end else if (!issue_now && ret_now && (inflight != '0)) begin
      inflight <= inflight - INF_W'(1);
    end
  end

  // Frame sequencer with registered strobes, write-back and ordering check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_en        <= 1'b0;
      rd_addr_col1 <= '0;
      rd_addr_col2 <= '0;
      wr_en        <= 1'b0;
      wr_addr_col1 <= '0;
      wr_addr_col2 <= '0;
      beats_q      <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      wr_en <= ret_now;

      if (ret_now) begin
        wr_addr_col1 <= dp_out_index_col1;
        wr_addr_col2 <= dp_out_index_col2;
        ret_cnt      <= ret_cnt + IDX_W'(1);
        if (dp_out_index_col1 != ret_cnt) begin
          err <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            ret_cnt <= '0;
            if (!len_ok) begin
              // Illegal length: flag it and finish immediately without issuing.
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err     <= 1'b0;
              busy    <= 1'b1;
              beats_q <= IDX_W'(1) << (len_log2 - 4'd1);
              state   <= ISSUE;
              // Beat 0 goes out on the start edge so rd_en follows start by one cycle.
              if (!sink_stall) begin
                rd_en        <= 1'b1;
                rd_addr_col1 <= '0;
                rd_addr_col2 <= IDX_W'(1) << (len_log2 - 4'd1);
                issue_cnt    <= IDX_W'(1);
              end else begin
                issue_cnt    <= '0;
              end
            end
          end
        end

        ISSUE: begin
          if (can_issue) begin
            rd_en        <= 1'b1;
            rd_addr_col1 <= issue_cnt;
            rd_addr_col2 <= issue_cnt + beats_q;
            issue_cnt    <= issue_cnt + IDX_W'(1);
            if ((issue_cnt + IDX_W'(1)) == beats_q) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (ret_cnt == beats_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  if (RD_LAT == 0) begin : g_rd_comb
    // Buffer data is available in the read cycle itself.
    always_comb begin
      dp_valid      = rd_en;
      dp_index_col1 = rd_addr_col1;
      dp_index_col2 = rd_addr_col2;
    end
  end else begin : g_rd_pipe
    logic [RD_LAT-1:0]            v_pipe;
    logic [RD_LAT-1:0][IDX_W-1:0] c1_pipe;
    logic [RD_LAT-1:0][IDX_W-1:0] c2_pipe;

    // Delay strobe and indices to line up with buffer data at the datapath inputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_pipe  <= '0;
        c1_pipe <= '0;
        c2_pipe <= '0;
      end else begin
        v_pipe[0]  <= rd_en;
        c1_pipe[0] <= rd_addr_col1;
        c2_pipe[0] <= rd_addr_col2;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
          v_pipe[i]  <= v_pipe[i-1];
          c1_pipe[i] <= c1_pipe[i-1];
          c2_pipe[i] <= c2_pipe[i-1];
        end
      end
    end

    assign dp_valid      = v_pipe[RD_LAT-1];
    assign dp_index_col1 = c1_pipe[RD_LAT-1];
    assign dp_index_col2 = c2_pipe[RD_LAT-1];
  end

`ifdef RECOVER_2N_SCHED_STATS_EN
  // Saturating frame statistics, cleared on accepted start and held after done.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_cycles <= '0;
      frame_cycles <= '0;
    end else begin
      if (busy && (frame_cycles != '1)) begin
        frame_cycles <= frame_cycles + 16'd1;
      end
      if ((state == ISSUE) && !can_issue && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_recover_2n_sched.sv
// Directed bench for recover_2n_sched: a default instance plus a MAX_INFLIGHT=2
// instance, a fixed-latency datapath model and a write-back scoreboard.
module tb_recover_2n_sched;
  localparam int IDX_W  = 11;
  localparam int DP_LAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic             start      [2] = '{default: 1'b0};
  logic [3:0]       len_log2   [2] = '{default: 4'd0};
  logic             sink_stall [2] = '{default: 1'b0};
  logic             dp_ready   [2] = '{default: 1'b0};
  logic [IDX_W-1:0] dp_out1    [2] = '{default: '0};
  logic [IDX_W-1:0] dp_out2    [2] = '{default: '0};
  logic             busy [2], done [2], err [2], rd_en [2], dp_valid [2], wr_en [2];
  logic [IDX_W-1:0] rd_addr_col1 [2], rd_addr_col2 [2];
  logic [IDX_W-1:0] dp_index_col1 [2], dp_index_col2 [2];
  logic [IDX_W-1:0] wr_addr_col1 [2], wr_addr_col2 [2];
`ifdef RECOVER_2N_SCHED_STATS_EN
  logic [15:0] stall_cycles [2], frame_cycles [2];
`endif

  recover_2n_sched u_dut (
    .clk(clk), .rst(rst), .start(start[0]), .len_log2(len_log2[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
`ifdef RECOVER_2N_SCHED_STATS_EN
    .stall_cycles(stall_cycles[0]), .frame_cycles(frame_cycles[0]),
`endif
    .sink_stall(sink_stall[0]), .rd_en(rd_en[0]),
    .rd_addr_col1(rd_addr_col1[0]), .rd_addr_col2(rd_addr_col2[0]),
    .dp_valid(dp_valid[0]), .dp_index_col1(dp_index_col1[0]), .dp_index_col2(dp_index_col2[0]),
    .dp_ready(dp_ready[0]), .dp_out_index_col1(dp_out1[0]), .dp_out_index_col2(dp_out2[0]),
    .wr_en(wr_en[0]), .wr_addr_col1(wr_addr_col1[0]), .wr_addr_col2(wr_addr_col2[0])
  );

  recover_2n_sched #(.MAX_INFLIGHT(2)) u_dut_lim (
    .clk(clk), .rst(rst), .start(start[1]), .len_log2(len_log2[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
`ifdef RECOVER_2N_SCHED_STATS_EN
    .stall_cycles(stall_cycles[1]), .frame_cycles(frame_cycles[1]),
`endif
    .sink_stall(sink_stall[1]), .rd_en(rd_en[1]),
    .rd_addr_col1(rd_addr_col1[1]), .rd_addr_col2(rd_addr_col2[1]),
    .dp_valid(dp_valid[1]), .dp_index_col1(dp_index_col1[1]), .dp_index_col2(dp_index_col2[1]),
    .dp_ready(dp_ready[1]), .dp_out_index_col1(dp_out1[1]), .dp_out_index_col2(dp_out2[1]),
    .wr_en(wr_en[1]), .wr_addr_col1(wr_addr_col1[1]), .wr_addr_col2(wr_addr_col2[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Datapath model: fixed DP_LAT from dp_valid to dp_ready, optional swap of beats 1/2.
  typedef struct { int due; int d; logic [IDX_W-1:0] c1; logic [IDX_W-1:0] c2; } dp_item_t;
  dp_item_t dpq[$];
  logic swap_en = 1'b0;

  always @(negedge clk) begin
    dp_item_t it;
    dp_ready[0] = 1'b0;
    dp_ready[1] = 1'b0;
    while (dpq.size() > 0 && dpq[0].due <= cyc) begin
      it = dpq.pop_front();
      dp_ready[it.d] = 1'b1;
      dp_out1[it.d]  = it.c1;
      dp_out2[it.d]  = it.c2;
    end
    for (int d = 0; d < 2; d++) begin
      if (dp_valid[d]) begin
        it.due = cyc + DP_LAT;
        it.d   = d;
        it.c1  = dp_index_col1[d];
        it.c2  = dp_index_col2[d];
        if (d == 0 && swap_en && it.c1 == IDX_W'(1)) begin
          it.c1 = IDX_W'(2); it.c2 = it.c2 + IDX_W'(1);
        end else if (d == 0 && swap_en && it.c1 == IDX_W'(2)) begin
          it.c1 = IDX_W'(1); it.c2 = it.c2 - IDX_W'(1);
        end
        dpq.push_back(it);
      end
    end
  end

  // Scoreboard: expected write-backs pushed by the stimulus, popped on wr_en.
  typedef struct packed { logic [IDX_W-1:0] c1; logic [IDX_W-1:0] c2; } wr_t;
  wr_t sb0[$];
  wr_t sb1[$];

  always @(negedge clk) begin
    wr_t e;
    if (wr_en[0]) begin
      if (sb0.size() == 0) chk("wr0_unexpected", {31'd0, wr_en[0]}, 32'd0);
      else begin
        e = sb0.pop_front();
        chk("wr0_col1", wr_addr_col1[0], e.c1);
        chk("wr0_col2", wr_addr_col2[0], e.c2);
      end
    end
    if (wr_en[1]) begin
      if (sb1.size() == 0) chk("wr1_unexpected", {31'd0, wr_en[1]}, 32'd0);
      else begin
        e = sb1.pop_front();
        chk("wr1_col1", wr_addr_col1[1], e.c1);
        chk("wr1_col2", wr_addr_col2[1], e.c2);
      end
    end
  end

  task automatic push_frame(input int d, input int l);
    int half;
    wr_t e;
    half = 1 << (l - 1);
    for (int b = 0; b < half; b++) begin
      e.c1 = IDX_W'(b);
      e.c2 = IDX_W'(b + half);
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
  endtask

  // Returns at the falling edge of the cycle after the start cycle.
  task automatic kick(input int d, input logic [3:0] l);
    @(negedge clk);
    start[d]    = 1'b1;
    len_log2[d] = l;
    @(negedge clk);
    start[d]    = 1'b0;
  endtask

  task automatic wait_done(input int d, input int limit, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done[d]) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdc, wrc, maxo, dcnt, dk;
    logic exp_b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctrl", {26'd0, busy[d], done[d], err[d], rd_en[d], dp_valid[d], wr_en[d]}, 32'd0);
      chk("rst_addr", {10'd0, rd_addr_col1[d] | rd_addr_col2[d], wr_addr_col1[d] | wr_addr_col2[d]}, 32'd0);
    end

    // Nominal frame, len_log2=3: exact cycle timing.
    push_frame(0, 3);
    kick(0, 4'd3);
    for (int k = 1; k <= 15; k++) begin
      exp_b = (k >= 1 && k <= 4);
      chk("nom_rd_en", {31'd0, rd_en[0]}, {31'd0, exp_b});
      if (exp_b) begin
        chk("nom_rd_c1", rd_addr_col1[0], k - 1);
        chk("nom_rd_c2", rd_addr_col2[0], k + 3);
      end
      exp_b = (k >= 2 && k <= 5);
      chk("nom_dp_valid", {31'd0, dp_valid[0]}, {31'd0, exp_b});
      if (exp_b) chk("nom_dp_c1", dp_index_col1[0], k - 2);
      chk("nom_wr_en", {31'd0, wr_en[0]}, {31'd0, (k >= 10 && k <= 13)});
      chk("nom_done", {31'd0, done[0]}, {31'd0, (k == 14)});
      chk("nom_busy", {31'd0, busy[0]}, {31'd0, (k >= 1 && k <= 13)});
      @(negedge clk);
    end
    chk("nom_err", {31'd0, err[0]}, 32'd0);
`ifdef RECOVER_2N_SCHED_STATS_EN
    chk("nom_frame_cycles", frame_cycles[0], 32'd13);
    chk("nom_stall_cycles", stall_cycles[0], 32'd0);
`endif

    // Inflight limit on the MAX_INFLIGHT=2 instance, len_log2=4.
    push_frame(1, 4);
    kick(1, 4'd4);
    rdc = 0; wrc = 0; maxo = 0; dk = 0;
    for (int i = 0; i < 300 && dk == 0; i++) begin
      if (rd_en[1]) rdc++;
      if (wr_en[1]) wrc++;
      if (rdc - wrc > maxo) maxo = rdc - wrc;
      if (done[1]) dk = 1;
      else @(negedge clk);
    end
    chk("lim_done_seen", dk, 32'd1);
    chk("lim_max_outstanding", maxo, 32'd2);
    chk("lim_rd_count", rdc, 32'd8);
    chk("lim_wr_count", wrc, 32'd8);
    chk("lim_err", {31'd0, err[1]}, 32'd0);
`ifdef RECOVER_2N_SCHED_STATS_EN
    chk("lim_stall_nonzero", {31'd0, (stall_cycles[1] != 16'd0)}, 32'd1);
`endif

    // Sink stall held in cycles 2..5 of a len_log2=4 frame.
    push_frame(0, 4);
    kick(0, 4'd4);
    dcnt = 0; dk = 0;
    for (int k = 1; k <= 24; k++) begin
      sink_stall[0] = (k >= 2 && k <= 5);
      exp_b = (k <= 2) || (k >= 7 && k <= 12);
      chk("stl_rd_en", {31'd0, rd_en[0]}, {31'd0, exp_b});
      if (exp_b) begin
        chk("stl_rd_c1", rd_addr_col1[0], (k <= 2) ? k - 1 : k - 5);
        chk("stl_rd_c2", rd_addr_col2[0], (k <= 2) ? k + 7 : k + 3);
      end
      if (done[0]) begin dcnt++; dk = k; end
      @(negedge clk);
    end
    sink_stall[0] = 1'b0;
    chk("stl_done_count", dcnt, 32'd1);
    chk("stl_done_cycle", dk, 32'd22);
    chk("stl_sb_empty", sb0.size(), 32'd0);
`ifdef RECOVER_2N_SCHED_STATS_EN
    chk("stl_stall_cycles", stall_cycles[0], 32'd4);
    chk("stl_frame_cycles", frame_cycles[0], 32'd21);
`endif

    // Ordering error: beats 1 and 2 come back swapped.
    sb0.push_back('{c1: IDX_W'(0), c2: IDX_W'(4)});
    sb0.push_back('{c1: IDX_W'(2), c2: IDX_W'(6)});
    sb0.push_back('{c1: IDX_W'(1), c2: IDX_W'(5)});
    sb0.push_back('{c1: IDX_W'(3), c2: IDX_W'(7)});
    swap_en = 1'b1;
    kick(0, 4'd3);
    wrc = 0; dk = 0;
    for (int i = 0; i < 60 && dk == 0; i++) begin
      if (wr_en[0]) begin
        wrc++;
        if (wrc == 1) chk("ord_err_first_write", {31'd0, err[0]}, 32'd0);
        if (wrc == 2) chk("ord_err_second_write", {31'd0, err[0]}, 32'd1);
      end
      if (done[0]) dk = 1;
      else @(negedge clk);
    end
    chk("ord_done_seen", dk, 32'd1);
    chk("ord_err_sticky", {31'd0, err[0]}, 32'd1);
    swap_en = 1'b0;
    push_frame(0, 2);
    kick(0, 4'd2);
    chk("ord_err_cleared", {31'd0, err[0]}, 32'd0);
    wait_done(0, 40, "ord_clean_done");
    chk("ord_clean_err", {31'd0, err[0]}, 32'd0);

    // Reset at cycle 5 of a len_log2=5 frame, held one cycle.
    push_frame(0, 5);
    kick(0, 4'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb0.delete();
    chk("mid_rst_ctrl", {26'd0, busy[0], done[0], err[0], rd_en[0], dp_valid[0], wr_en[0]}, 32'd0);
    chk("mid_rst_rd_addr", {10'd0, rd_addr_col1[0], rd_addr_col2[0]}, 32'd0);
    chk("mid_rst_dp_idx", {10'd0, dp_index_col1[0], dp_index_col2[0]}, 32'd0);
    chk("mid_rst_wr_addr", {10'd0, wr_addr_col1[0], wr_addr_col2[0]}, 32'd0);
    wrc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wr_en[0]) wrc++;
    end
    chk("mid_rst_no_late_writes", wrc, 32'd0);
    push_frame(0, 3);
    kick(0, 4'd3);
    wait_done(0, 40, "post_rst_done");
    chk("post_rst_err", {31'd0, err[0]}, 32'd0);

    // Illegal lengths: immediate done with err, no issue.
    kick(0, 4'd12);
    chk("ill12_done", {31'd0, done[0]}, 32'd1);
    chk("ill12_err", {31'd0, err[0]}, 32'd1);
    kick(0, 4'd1);
    chk("ill1_done", {31'd0, done[0]}, 32'd1);
    chk("ill1_err", {31'd0, err[0]}, 32'd1);
    chk("ill1_busy", {31'd0, busy[0]}, 32'd0);
    rdc = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_en[0]) rdc++;
      @(negedge clk);
    end
    chk("ill1_no_rd", rdc, 32'd0);
    chk("ill1_done_one_cycle", {31'd0, done[0]}, 32'd0);

    // Start while busy is ignored.
    push_frame(0, 3);
    kick(0, 4'd3);
    rdc = 0; dk = 0;
    for (int i = 0; i < 40 && dk == 0; i++) begin
      if (i == 2) begin start[0] = 1'b1; len_log2[0] = 4'd2; end
      else start[0] = 1'b0;
      if (rd_en[0]) rdc++;
      if (done[0]) dk = 1;
      else @(negedge clk);
    end
    start[0] = 1'b0;
    chk("bsy_done_seen", dk, 32'd1);
    chk("bsy_rd_count", rdc, 32'd4);
    chk("bsy_err_cleared", {31'd0, err[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("bsy_idle_after", {31'd0, busy[0]}, 32'd0);

    repeat (12) @(negedge clk);
    chk("final_sb0_empty", sb0.size(), 32'd0);
    chk("final_sb1_empty", sb1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
